// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: loops a working register through a single-position
// shifter `amount` times to build LSL/LSR/ASR/ROL by 0..15 with start/busy/done.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_count;
  logic [1:0]       r_op;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;

  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  logic [WIDTH-1:0] w_work_nxt;
  logic             w_carry_nxt;

  // Single-position shifter the sequencer wraps.
  assign w_left  = {r_work[WIDTH-2:0], 1'b0};
  assign w_right = {1'b0, r_work[WIDTH-1:1]};

  always_comb begin
    w_work_nxt  = w_left;
    w_carry_nxt = r_work[WIDTH-1];
    case (r_op)
      OP_LSL: begin
        w_work_nxt  = w_left;
        w_carry_nxt = r_work[WIDTH-1];
      end
      OP_LSR: begin
        w_work_nxt  = w_right;
        w_carry_nxt = r_work[0];
      end
      OP_ASR: begin
        w_work_nxt  = {r_work[WIDTH-1], w_right[WIDTH-2:0]};
        w_carry_nxt = r_work[0];
      end
      OP_ROL: begin
        w_work_nxt  = {w_left[WIDTH-1:1], r_work[WIDTH-1]};
        w_carry_nxt = r_work[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_count     <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work  <= a;
            r_op    <= op;
            r_count <= amount;
            r_carry <= 1'b0;
            if (amount != '0) begin
              r_state <= S_SHIFT;
            end else begin
              // Zero-length shift goes straight to DONE with the operand untouched.
              r_state     <= S_DONE;
              r_result    <= a;
              r_carry_out <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          r_work  <= w_work_nxt;
          r_carry <= w_carry_nxt;
          r_count <= r_count - 1'b1;
          if (r_count == AMT_W'(1)) begin
            r_state     <= S_DONE;
            r_result    <= w_work_nxt;
            r_carry_out <= w_carry_nxt;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vectors, random ops against
// an arithmetic reference model, and multi-cycle handshake corner cases.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [3:0]  amount = '0;
  logic [15:0] a = '0;
  logic        busy, done, carry_out;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount), .a(a),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] a;
    logic [15:0] res;
    logic        c;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // Reference: whole-word shifts computed in one step, carry = last bit out.
  task automatic model(input logic [1:0] o, input logic [3:0] amt, input logic [15:0] av,
                       output logic [15:0] res, output logic c);
    logic [31:0] full;
    case (o)
      2'b00: begin full = {16'h0, av} << amt; res = full[15:0];  c = (amt != 0) ? full[16] : 1'b0; end
      2'b01: begin full = {av, 16'h0} >> amt; res = full[31:16]; c = (amt != 0) ? full[15] : 1'b0; end
      2'b10: begin full = $signed({av, 16'h0}) >>> amt; res = full[31:16]; c = (amt != 0) ? full[15] : 1'b0; end
      default: begin
        full = ({16'h0, av} << amt) | ({16'h0, av} >> (16 - int'(amt)));
        res = full[15:0];
        c = (amt != 0) ? full[0] : 1'b0;
      end
    endcase
  endtask

  // Issue one request from IDLE, scramble inputs after accept, check latency and result.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [3:0] amt,
                        input logic [15:0] av, input logic [15:0] er, input logic ec);
    int k;
    int nbusy;
    bit seen;
    @(negedge clk);
    op = o; amount = amt; a = av; start = 1'b1;
    @(posedge clk);
    seen = 0; nbusy = 0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      start = 1'b0; a = 16'($urandom); op = 2'($urandom); amount = 4'($urandom);
      k++;
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    check({nm, " latency"}, k, int'(amt) + 1);
    check({nm, " busy_cycles"}, nbusy, int'(amt) + 1);
    check({nm, " result"}, result, er);
    check({nm, " carry"}, carry_out, ec);
    @(negedge clk);
    check({nm, " done_pulse"}, {busy, done}, 2'b00);
    check({nm, " result_held"}, result, er);
  endtask

  initial begin
    logic [15:0] er;
    logic        ec;
    logic [1:0]  ro;
    logic [3:0]  ra;
    logic [15:0] rv;
    bit          seen;
    int          k;
    logic [7:0]  busy_seq, done_seq;

    tbl[0] = '{2'b00, 4'd1,  16'h8001, 16'h0002, 1'b1};
    tbl[1] = '{2'b10, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
    tbl[2] = '{2'b11, 4'd4,  16'h1234, 16'h2341, 1'b1};
    tbl[3] = '{2'b01, 4'd4,  16'h1234, 16'h0123, 1'b0};
    tbl[4] = '{2'b01, 4'd0,  16'hABCD, 16'hABCD, 1'b0};
    tbl[5] = '{2'b00, 4'd15, 16'hFFFF, 16'h8000, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, carry_out, result}, 19'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].amt, tbl[i].a, tbl[i].res, tbl[i].c);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom); ra = 4'($urandom); rv = 16'($urandom);
      model(ro, ra, rv, er, ec);
      run_op($sformatf("rnd%0d op%0d amt%0d a%0h", i, ro, ra, rv), ro, ra, rv, er, ec);
    end

    // start pulsed mid-SHIFT must be ignored.
    @(negedge clk);
    op = 2'b11; amount = 4'd4; a = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 2'b00; amount = 4'd1; a = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; k = 0;
    while (!seen && k < 20) begin
      if (done) seen = 1; else begin @(negedge clk); k++; end
    end
    check("ignore_start seen_done", seen, 1);
    check("ignore_start result", result, 16'h2341);
    check("ignore_start carry", carry_out, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("ignore_start stays_idle", {busy, done}, 2'b00);

    // Reset aborts an in-flight shift.
    op = 2'b10; amount = 4'd15; a = 16'h8000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_shift busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort busy_done", {busy, done}, 2'b00);
    check("rst_abort result", result, 16'h0);
    check("rst_abort carry", carry_out, 1'b0);
    repeat (20) @(negedge clk);
    check("rst_abort no_late_done", {busy, done}, 2'b00);
    run_op("after_rst", 2'b01, 4'd3, 16'h00F8, 16'h001F, 1'b0);

    // start held high: accepts only after DONE plus one IDLE cycle.
    @(negedge clk);
    op = 2'b00; amount = 4'd2; a = 16'h0003; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      busy_seq[7-i] = busy;
      done_seq[7-i] = done;
      if (done) begin
        check($sformatf("b2b result@%0d", i), result, 16'h000C);
        check($sformatf("b2b carry@%0d", i), carry_out, 1'b0);
      end
    end
    start = 1'b0;
    check("b2b busy_pattern", busy_seq, 8'b1110_1110);
    check("b2b done_pattern", done_seq, 8'b0010_0010);
    repeat (4) @(negedge clk);
    check("b2b idle_after", {busy, done}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
